cam_lookup_ctrl: RTL and testbench
==================================

Name: cam_lookup_ctrl

Overview:
- Initiator side of the CAM interface. Accepts key lookup requests over a valid/ready handshake and searches the CAM.
- On a hit, returns the matching index. On a miss, allocates an entry: round-robin write, then read-back verify, then returns the allocated index.
- Sits between the client datapath and the CAM. Drives the CAM's write/read/search inputs and consumes its read/search outputs.

Parameters:
- ARRAY_WIDTH_LOG2, 5, log2 of key width (key = 2**ARRAY_WIDTH_LOG2 bits).
- ARRAY_SIZE_LOG2, 5, log2 of CAM entry count (N = 2**ARRAY_SIZE_LOG2).

Ports:
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid_i  in  1  client request valid.
- req_ready_o  out  1  controller can accept a request.
- req_key_i  in  2**ARRAY_WIDTH_LOG2  lookup key.
- resp_valid_o  out  1  response valid; held until accepted.
- resp_ready_i  in  1  client accepts response.
- resp_index_o  out  ARRAY_SIZE_LOG2  hit or allocated entry index.
- resp_hit_o  out  1  1 = key was present; 0 = newly allocated.
- resp_evict_o  out  1  allocation overwrote a valid entry (CAM was full).
- resp_error_o  out  1  read-back verify mismatch.
- occupancy_o  out  ARRAY_SIZE_LOG2+1  valid entries written since reset, saturating at N.
- cam_write_o  out  1  CAM write enable.
- cam_write_index_o  out  ARRAY_SIZE_LOG2  CAM write index.
- cam_write_data_o  out  2**ARRAY_WIDTH_LOG2  CAM write data.
- cam_read_o  out  1  CAM read enable.
- cam_read_index_o  out  ARRAY_SIZE_LOG2  CAM read index.
- cam_search_o  out  1  CAM search enable.
- cam_search_data_o  out  2**ARRAY_WIDTH_LOG2  CAM search key.
- cam_read_valid_i  in  1  CAM read hit on a written entry (combinational from CAM).
- cam_read_value_i  in  2**ARRAY_WIDTH_LOG2  CAM read data.
- cam_search_valid_i  in  1  CAM search found (combinational from CAM).
- cam_search_index_i  in  ARRAY_SIZE_LOG2  lowest matching CAM index.

Behaviour:
- Reset (reset=0, async): state=IDLE; key_q=0, alloc_ptr=0, occupancy=0. All outputs 0 except req_ready_o=1. Any in-flight transaction is discarded with no response.
- FSM states: IDLE, SEARCH, WRITE, VERIFY, RESP. CAM control outputs are Moore (decoded from state, key_q, alloc_ptr/idx_q only).
- IDLE:
  - req_ready_o=1.
  - On req_valid_i&&req_ready_o, latch key_q=req_key_i and go to SEARCH.
  - No other state asserts req_ready_o (one outstanding request).
- SEARCH:
  - cam_search_o=1, cam_search_data_o=key_q. Sample cam_search_valid_i/cam_search_index_i at the clock edge.
  - Found: idx_q=cam_search_index_i, hit=1, evict=0, error=0; go to RESP.
  - Not found: idx_q=alloc_ptr, evict=(occupancy==N); go to WRITE.
- WRITE:
  - cam_write_o=1, cam_write_index_o=idx_q, cam_write_data_o=key_q.
  - At the edge: alloc_ptr = alloc_ptr+1 mod N (wraps N-1 -> 0); occupancy++ unless already N.
  - Go to VERIFY.
- VERIFY:
  - cam_read_o=1, cam_read_index_o=idx_q.
  - error = !(cam_read_valid_i && cam_read_value_i==key_q); hit=0. Go to RESP.
- RESP:
  - resp_valid_o=1, with resp_index_o/hit/evict/error from registers, stable while resp_ready_i=0.
  - On resp_ready_i=1, go to IDLE. req_ready_o returns next cycle.
- Latency from accept edge to resp_valid_o: hit = 2 cycles, miss = 4 cycles. Minimum request spacing: hit 3 cycles, miss 5 cycles.
- Unused CAM controls are 0 in every state. cam_*_data_o/index_o are don't-care when their enable is 0, but must be driven (no X).
- Replacement is pure round-robin on alloc_ptr; no search-hit refresh. When full, the oldest-allocated slot is overwritten and resp_evict_o=1.
- Duplicate keys cannot be created by this block: a miss is always followed by the write of that key.
- A req_valid_i change while not in IDLE is ignored; the client must hold the request until the handshake.

Test Plan:
- Reset, then request key 32'hDEAD_BEEF into an empty CAM -> search miss, write idx 0, verify ok. resp_valid_o 4 cycles after accept: index=0, hit=0, evict=0, error=0; occupancy_o=1.
- Repeat key 32'hDEAD_BEEF -> resp 2 cycles after accept: index=0, hit=1; no cam_write_o pulse; occupancy_o stays 1.
- 32 distinct keys 0..31 then key 100 -> keys get indices 0..31 with occupancy_o=32. Key 100 gets index 0, evict=1. Subsequent search for key 0 misses.
- resp_ready_i held 0 for 5 cycles in RESP -> resp_valid_o and all resp fields stable; req_ready_o=0 throughout; IDLE on first resp_ready_i=1.
- Bench CAM model forces cam_read_value_i mismatch in VERIFY -> resp_error_o=1, hit=0, alloc_ptr still advanced.
- Assert reset=0 asynchronously mid-WRITE -> outputs zero immediately (req_ready_o=1), no resp_valid_o. alloc_ptr and occupancy_o back to 0; next miss allocates index 0.

Source files
------------

// File: rtl/cam_lookup_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cam_lookup_ctrl
// Purpose  : CAM initiator. Searches a key and returns the hit index. On a miss
//            it allocates round-robin, writes the key, reads it back, and
//            returns the new index.
// Revision : 1.0  initial release
// ============================================================================
module cam_lookup_ctrl #(
  parameter int ARRAY_WIDTH_LOG2 = 5,
  parameter int ARRAY_SIZE_LOG2  = 5
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              req_valid_i,
  output logic                              req_ready_o,
  input  logic [(2**ARRAY_WIDTH_LOG2)-1:0]  req_key_i,
  output logic                              resp_valid_o,
  input  logic                              resp_ready_i,
  output logic [ARRAY_SIZE_LOG2-1:0]        resp_index_o,
  output logic                              resp_hit_o,
  output logic                              resp_evict_o,
  output logic                              resp_error_o,
  output logic [ARRAY_SIZE_LOG2:0]          occupancy_o,
  output logic                              cam_write_o,
  output logic [ARRAY_SIZE_LOG2-1:0]        cam_write_index_o,
  output logic [(2**ARRAY_WIDTH_LOG2)-1:0]  cam_write_data_o,
  output logic                              cam_read_o,
  output logic [ARRAY_SIZE_LOG2-1:0]        cam_read_index_o,
  output logic                              cam_search_o,
  output logic [(2**ARRAY_WIDTH_LOG2)-1:0]  cam_search_data_o,
  input  logic                              cam_read_valid_i,
  input  logic [(2**ARRAY_WIDTH_LOG2)-1:0]  cam_read_value_i,
  input  logic                              cam_search_valid_i,
  input  logic [ARRAY_SIZE_LOG2-1:0]        cam_search_index_i
);

  localparam int c_key_w = 2**ARRAY_WIDTH_LOG2;
  localparam logic [ARRAY_SIZE_LOG2:0] c_full = (ARRAY_SIZE_LOG2+1)'(1) << ARRAY_SIZE_LOG2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SEARCH = 3'd1,
    S_WRITE  = 3'd2,
    S_VERIFY = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  state_t                     r_state;
  logic [c_key_w-1:0]         r_key;
  logic [ARRAY_SIZE_LOG2-1:0] r_idx;
  logic [ARRAY_SIZE_LOG2-1:0] r_alloc;
  logic [ARRAY_SIZE_LOG2:0]   r_occ;

  // Index and data buses follow the holding registers; only the enables are state-decoded.
  assign resp_index_o      = r_idx;
  assign occupancy_o       = r_occ;
  assign cam_write_index_o = r_idx;
  assign cam_write_data_o  = r_key;
  assign cam_read_index_o  = r_idx;
  assign cam_search_data_o = r_key;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_key        <= '0;
      r_idx        <= '0;
      r_alloc      <= '0;
      r_occ        <= '0;
      req_ready_o  <= 1'b1;
      resp_valid_o <= 1'b0;
      resp_hit_o   <= 1'b0;
      resp_evict_o <= 1'b0;
      resp_error_o <= 1'b0;
      cam_write_o  <= 1'b0;
      cam_read_o   <= 1'b0;
      cam_search_o <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid_i) begin
            r_key        <= req_key_i;
            req_ready_o  <= 1'b0;
            cam_search_o <= 1'b1;
            r_state      <= S_SEARCH;
          end
        end
        S_SEARCH: begin
          cam_search_o <= 1'b0;
          resp_error_o <= 1'b0;
          if (cam_search_valid_i) begin
            r_idx        <= cam_search_index_i;
            resp_hit_o   <= 1'b1;
            resp_evict_o <= 1'b0;
            resp_valid_o <= 1'b1;
            r_state      <= S_RESP;
          end else begin
            r_idx        <= r_alloc;
            resp_hit_o   <= 1'b0;
            resp_evict_o <= (r_occ == c_full);
            cam_write_o  <= 1'b1;
            r_state      <= S_WRITE;
          end
        end
        S_WRITE: begin
          cam_write_o <= 1'b0;
          cam_read_o  <= 1'b1;
          r_alloc     <= r_alloc + 1'b1;
          if (r_occ != c_full) begin
            r_occ <= r_occ + 1'b1;
          end
          r_state <= S_VERIFY;
        end
        S_VERIFY: begin
          cam_read_o   <= 1'b0;
          resp_hit_o   <= 1'b0;
          resp_error_o <= !(cam_read_valid_i && (cam_read_value_i == r_key));
          resp_valid_o <= 1'b1;
          r_state      <= S_RESP;
        end
        S_RESP: begin
          if (resp_ready_i) begin
            resp_valid_o <= 1'b0;
            req_ready_o  <= 1'b1;
            r_state      <= S_IDLE;
          end
        end
        default: begin
          resp_valid_o <= 1'b0;
          req_ready_o  <= 1'b1;
          cam_write_o  <= 1'b0;
          cam_read_o   <= 1'b0;
          cam_search_o <= 1'b0;
          r_state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cam_lookup_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cam_lookup_ctrl
// Purpose  : Directed self-checking bench for cam_lookup_ctrl with a CAM model.
// Revision : 1.0  initial release
// ============================================================================
module tb_cam_lookup_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [31:0] req_key_i = '0;
  logic        resp_valid_o;
  logic        resp_ready_i = 1'b0;
  logic [4:0]  resp_index_o;
  logic        resp_hit_o, resp_evict_o, resp_error_o;
  logic [5:0]  occupancy_o;
  logic        cam_write_o, cam_read_o, cam_search_o;
  logic [4:0]  cam_write_index_o, cam_read_index_o;
  logic [31:0] cam_write_data_o, cam_search_data_o;
  logic        cam_read_valid_i;
  logic [31:0] cam_read_value_i;
  logic        cam_search_valid_i;
  logic [4:0]  cam_search_index_i;

  logic [31:0] m_key [32];
  logic        m_v   [32];
  logic        model_clear = 1'b1;
  logic [31:0] corrupt = '0;

  int n_checks = 0;
  int n_fail   = 0;

  cam_lookup_ctrl #(.ARRAY_WIDTH_LOG2(5), .ARRAY_SIZE_LOG2(5)) dut (
    .clk(clk), .reset(rst_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_key_i(req_key_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
    .resp_index_o(resp_index_o), .resp_hit_o(resp_hit_o),
    .resp_evict_o(resp_evict_o), .resp_error_o(resp_error_o),
    .occupancy_o(occupancy_o),
    .cam_write_o(cam_write_o), .cam_write_index_o(cam_write_index_o),
    .cam_write_data_o(cam_write_data_o),
    .cam_read_o(cam_read_o), .cam_read_index_o(cam_read_index_o),
    .cam_search_o(cam_search_o), .cam_search_data_o(cam_search_data_o),
    .cam_read_valid_i(cam_read_valid_i), .cam_read_value_i(cam_read_value_i),
    .cam_search_valid_i(cam_search_valid_i), .cam_search_index_i(cam_search_index_i)
  );

  always #5 clk = ~clk;

  // CAM model: lowest matching index wins; read data may be corrupted on demand.
  always_comb begin
    cam_search_valid_i = 1'b0;
    cam_search_index_i = '0;
    for (int i = 31; i >= 0; i--) begin
      if (m_v[i] && (m_key[i] == cam_search_data_o)) begin
        cam_search_valid_i = 1'b1;
        cam_search_index_i = 5'(i);
      end
    end
    cam_read_valid_i = m_v[cam_read_index_o];
    cam_read_value_i = m_key[cam_read_index_o] ^ corrupt;
  end

  always @(posedge clk) begin
    if (model_clear) begin
      for (int i = 0; i < 32; i++) begin
        m_v[i]   <= 1'b0;
        m_key[i] <= '0;
      end
    end else if (cam_write_o) begin
      m_key[cam_write_index_o] <= cam_write_data_o;
      m_v[cam_write_index_o]   <= 1'b1;
    end
  end

  // Issues one request; returns latency (accept edge to first sampled resp_valid_o),
  // number of write pulses seen, and the response fields. Leaves RESP pending if ack=0.
  task automatic do_req(input logic [31:0] key, input logic ack, output int lat,
                        output int wr, output logic [4:0] idx, output logic hit,
                        output logic evict, output logic err);
    lat = -1; wr = 0; idx = '0; hit = 1'b0; evict = 1'b0; err = 1'b0;
    @(negedge clk);
    req_valid_i = 1'b1;
    req_key_i   = key;
    for (int k = 0; k < 20 && !req_ready_o; k++) @(negedge clk);
    @(posedge clk);
    #1 req_valid_i = 1'b0;
    for (int cnt = 0; cnt < 20; cnt++) begin
      @(negedge clk);
      if (resp_valid_o) begin
        lat = cnt + 1;
        break;
      end
      if (cam_write_o) wr++;
      @(posedge clk);
    end
    idx = resp_index_o; hit = resp_hit_o; evict = resp_evict_o; err = resp_error_o;
    if (ack && lat > 0) begin
      resp_ready_i = 1'b1;
      @(posedge clk);
      #1 resp_ready_i = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; model_clear = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (req_ready_o !== 1'b1 || resp_valid_o !== 1'b0 || occupancy_o !== 6'd0) begin
      n_fail++;
      $display("FAIL reset_ctrl: ready=%b valid=%b occ=%0d required ready=1 valid=0 occ=0",
               req_ready_o, resp_valid_o, occupancy_o);
    end
    n_checks++;
    if ({cam_write_o, cam_read_o, cam_search_o} !== 3'b000 || cam_search_data_o !== 32'h0 ||
        cam_write_index_o !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_cam: w/r/s=%b%b%b data=%h idx=%0d required 000 0 0",
               cam_write_o, cam_read_o, cam_search_o, cam_search_data_o, cam_write_index_o);
    end
    rst_n = 1'b1; model_clear = 1'b0;
  endtask

  task automatic test_miss();
    int lat, wr; logic [4:0] idx; logic hit, ev, err;
    do_req(32'hDEAD_BEEF, 1'b1, lat, wr, idx, hit, ev, err);
    n_checks++;
    if (lat !== 4) begin n_fail++; $display("FAIL miss_latency: got %0d required 4", lat); end
    n_checks++;
    if ({idx, hit, ev, err} !== {5'd0, 3'b000} || wr !== 1) begin
      n_fail++;
      $display("FAIL miss_resp: idx=%0d hit=%b evict=%b err=%b writes=%0d required 0 0 0 0 1",
               idx, hit, ev, err, wr);
    end
    n_checks++;
    if (occupancy_o !== 6'd1) begin n_fail++; $display("FAIL miss_occ: got %0d required 1", occupancy_o); end
  endtask

  task automatic test_hit();
    int lat, wr; logic [4:0] idx; logic hit, ev, err;
    do_req(32'hDEAD_BEEF, 1'b1, lat, wr, idx, hit, ev, err);
    n_checks++;
    if (lat !== 2) begin n_fail++; $display("FAIL hit_latency: got %0d required 2", lat); end
    n_checks++;
    if ({idx, hit, ev, err} !== {5'd0, 3'b100} || wr !== 0) begin
      n_fail++;
      $display("FAIL hit_resp: idx=%0d hit=%b evict=%b err=%b writes=%0d required 0 1 0 0 0",
               idx, hit, ev, err, wr);
    end
    n_checks++;
    if (occupancy_o !== 6'd1) begin n_fail++; $display("FAIL hit_occ: got %0d required 1", occupancy_o); end
  endtask

  task automatic test_hold();
    int lat, wr; logic [4:0] idx; logic hit, ev, err;
    do_req(32'h1234_5678, 1'b0, lat, wr, idx, hit, ev, err);
    n_checks++;
    if (lat !== 4 || idx !== 5'd1) begin
      n_fail++; $display("FAIL hold_first: lat=%0d idx=%0d required 4 1", lat, idx);
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_checks++;
      if (resp_valid_o !== 1'b1 || req_ready_o !== 1'b0 || resp_index_o !== 5'd1 ||
          {resp_hit_o, resp_evict_o, resp_error_o} !== 3'b000) begin
        n_fail++;
        $display("FAIL hold_stable: cyc=%0d valid=%b ready=%b idx=%0d h/e/r=%b%b%b required 1 0 1 000",
                 c, resp_valid_o, req_ready_o, resp_index_o, resp_hit_o, resp_evict_o, resp_error_o);
      end
    end
    resp_ready_i = 1'b1;
    @(posedge clk);
    #1 resp_ready_i = 1'b0;
    @(negedge clk);
    n_checks++;
    if (req_ready_o !== 1'b1 || resp_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL hold_release: ready=%b valid=%b required 1 0", req_ready_o, resp_valid_o);
    end
  endtask

  task automatic test_verify_error();
    int lat, wr; logic [4:0] idx; logic hit, ev, err;
    corrupt = 32'h0000_0100;
    do_req(32'hCAFE_0001, 1'b1, lat, wr, idx, hit, ev, err);
    corrupt = '0;
    n_checks++;
    if ({idx, hit, err} !== {5'd2, 2'b01}) begin
      n_fail++; $display("FAIL verify_err: idx=%0d hit=%b err=%b required 2 0 1", idx, hit, err);
    end
    do_req(32'hCAFE_0002, 1'b1, lat, wr, idx, hit, ev, err);
    n_checks++;
    if ({idx, hit, err} !== {5'd3, 2'b00} || occupancy_o !== 6'd4) begin
      n_fail++;
      $display("FAIL verify_after: idx=%0d hit=%b err=%b occ=%0d required 3 0 0 4", idx, hit, err, occupancy_o);
    end
  endtask

  task automatic test_fill_evict();
    int lat, wr; logic [4:0] idx; logic hit, ev, err;
    test_reset();
    for (int i = 0; i < 32; i++) begin
      do_req(32'(i), 1'b1, lat, wr, idx, hit, ev, err);
      n_checks++;
      if ({idx, hit, ev, err} !== {5'(i), 3'b000}) begin
        n_fail++;
        $display("FAIL fill_key%0d: idx=%0d hit=%b evict=%b err=%b required %0d 0 0 0", i, idx, hit, ev, err, i);
      end
    end
    n_checks++;
    if (occupancy_o !== 6'd32) begin n_fail++; $display("FAIL fill_occ: got %0d required 32", occupancy_o); end
    do_req(32'd100, 1'b1, lat, wr, idx, hit, ev, err);
    n_checks++;
    if ({idx, hit, ev, err} !== {5'd0, 3'b010} || occupancy_o !== 6'd32) begin
      n_fail++;
      $display("FAIL evict_100: idx=%0d hit=%b evict=%b err=%b occ=%0d required 0 0 1 0 32",
               idx, hit, ev, err, occupancy_o);
    end
    do_req(32'd0, 1'b1, lat, wr, idx, hit, ev, err);
    n_checks++;
    if ({idx, hit, ev} !== {5'd1, 2'b01} || lat !== 4) begin
      n_fail++;
      $display("FAIL evicted_key0: idx=%0d hit=%b evict=%b lat=%0d required 1 0 1 4", idx, hit, ev, lat);
    end
  endtask

  task automatic test_reset_midwrite();
    int lat, wr; logic [4:0] idx; logic hit, ev, err;
    @(negedge clk);
    req_valid_i = 1'b1; req_key_i = 32'h5555_AAAA;
    @(posedge clk);
    #1 req_valid_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (cam_write_o !== 1'b1) begin n_fail++; $display("FAIL midwrite_reach: write=%b required 1", cam_write_o); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (req_ready_o !== 1'b1 || cam_write_o !== 1'b0 || resp_valid_o !== 1'b0 || occupancy_o !== 6'd0) begin
      n_fail++;
      $display("FAIL midwrite_async: ready=%b write=%b valid=%b occ=%0d required 1 0 0 0",
               req_ready_o, cam_write_o, resp_valid_o, occupancy_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (resp_valid_o !== 1'b0) begin n_fail++; $display("FAIL midwrite_noresp: valid=%b required 0", resp_valid_o); end
    do_req(32'h7777_0000, 1'b1, lat, wr, idx, hit, ev, err);
    n_checks++;
    if ({idx, hit, ev, err} !== {5'd0, 3'b000} || occupancy_o !== 6'd1) begin
      n_fail++;
      $display("FAIL midwrite_next: idx=%0d hit=%b evict=%b err=%b occ=%0d required 0 0 0 0 1",
               idx, hit, ev, err, occupancy_o);
    end
  endtask

  initial begin
    test_reset();
    test_miss();
    test_hit();
    test_hold();
    test_verify_error();
    test_fill_evict();
    test_reset_midwrite();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
